// File: rtl/txb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | txb_pkg : shared state encoding and line-ending bytes for tx_line_buf   |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
package txb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CR    = 2'd2,
        ST_LF    = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/txb_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | txb_fifo : byte FIFO with combinational head and separate occupancy ctr |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
module txb_fifo #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == c_full_count);
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tx_line_buf.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tx_line_buf : line buffer draining a byte snapshot to the UART on print |
// | Optional CR/LF trailer per drain when TXBUF_CRLF_EN is defined.         |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
module tx_line_buf
    import txb_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          print,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          busy,
    output logic          overflow
);

    localparam logic [AW:0] c_one = {{AW{1'b0}}, 1'b1};
`ifdef TXBUF_CRLF_EN
    localparam state_t c_drain_done = ST_CR;
`else
    localparam state_t c_drain_done = ST_IDLE;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [AW:0] r_remaining;
    logic [AW:0] w_remaining_nxt;
    logic        r_overflow;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;

    // Admission uses the pre-edge full flag, so a same-cycle pop never frees room.
    assign w_push = wr_en & ~full;

    txb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (wr_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            if (wr_en && full) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_pop           = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (print) begin
                    w_remaining_nxt = count + {{AW{1'b0}}, w_push};
                    if ((count != '0) || w_push)
                        w_state_nxt = ST_DRAIN;
`ifdef TXBUF_CRLF_EN
                    else
                        w_state_nxt = ST_CR;
`endif
                end
            end
            ST_DRAIN: begin
                tx_valid = 1'b1;
                tx_data  = w_head;
                if (tx_ready) begin
                    w_pop           = 1'b1;
                    w_remaining_nxt = r_remaining - c_one;
                    if (r_remaining == c_one) w_state_nxt = c_drain_done;
                end
            end
`ifdef TXBUF_CRLF_EN
            ST_CR: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_CR;
                if (tx_ready) w_state_nxt = ST_LF;
            end
            ST_LF: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
                if (tx_ready) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign overflow = r_overflow;

endmodule
`default_nettype wire
